instr_cache: RTL and testbench

//  Direct-mapped instruction cache between instruction fetch and memory_controller's instr port.

---
 rtl/instr_cache.sv | 113 +++++++++++
 tb/tb_instr_cache.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: 8-byte lines, one-cycle hits, single line fill per miss.
// Define ICACHE_PERF_EN to add the hit_count / miss_count performance counters.
module instr_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_signal,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        mc_signal,
  output logic [31:0] mc_a,
  input  logic [63:0] mc_d,
  input  logic        mc_done,
`ifdef ICACHE_PERF_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  output logic        dbg_state
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 29 - INDEX_BITS;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

  state_t                  state, next_state;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [63:0]             data_mem [LINES];
  logic [31:3]             line_q;
  logic                    word_q;

  logic [INDEX_BITS-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    hit, lookup, do_hit, do_miss, do_fill;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^if_pc[1:0];

  assign req_idx  = if_pc[3 +: INDEX_BITS];
  assign req_tag  = if_pc[31 -: TAG_W];
  assign fill_idx = line_q[3 +: INDEX_BITS];
  assign mc_a     = {line_q, 3'b000};
  assign dbg_state = state;

  // Handshake: mc_signal requests a line while in MISS; it drops in the mc_done
  // cycle (and on clear) so the controller never launches a second fetch.
  always_comb begin
    next_state = state;
    hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    lookup     = rdy_in && if_req && !clear_signal && (state == IDLE);
    do_hit     = lookup && hit;
    do_miss    = lookup && !hit;
    do_fill    = rdy_in && (state == MISS) && mc_done && !clear_signal;
    mc_signal  = (state == MISS) && !mc_done && !clear_signal;
    if (rdy_in) begin
      case (state)
        IDLE: if (do_miss) next_state = MISS;
        MISS: if (clear_signal || mc_done) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      valid_q  <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      line_q   <= '0;
      word_q   <= 1'b0;
    end else begin
      state    <= next_state;
      if_valid <= do_hit || do_fill;
      if (do_hit)
        if_instr <= if_pc[2] ? data_mem[req_idx][63:32] : data_mem[req_idx][31:0];
      if (do_fill) begin
        if_instr          <= word_q ? mc_d[63:32] : mc_d[31:0];
        valid_q[fill_idx] <= 1'b1;
      end
      if (do_miss) begin
        line_q <= if_pc[31:3];
        word_q <= if_pc[2];
      end
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_in) begin
    if (do_fill) begin
      tag_mem[fill_idx]  <= line_q[31 -: TAG_W];
      data_mem[fill_idx] <= mc_d;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit_count  <= hit_count + 32'(do_hit);
      miss_count <= miss_count + 32'(do_miss);
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Bench for instr_cache: directed scenarios then randomized fetches against a line-level model.
// Define ICACHE_PERF_EN to also check the performance counters.
module tb_instr_cache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_signal;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        mc_signal;
  logic [31:0] mc_a;
  logic [63:0] mc_d;
  logic        mc_done;
  logic        dbg_state;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  instr_cache #(.INDEX_BITS(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .if_req(if_req), .if_pc(if_pc), .if_valid(if_valid), .if_instr(if_instr),
    .mc_signal(mc_signal), .mc_a(mc_a), .mc_d(mc_d), .mc_done(mc_done),
`ifdef ICACHE_PERF_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // reference model: which memory line each cache slot holds, plus backing memory
  int          n_vec = 0;
  int          n_err = 0;
  bit          m_valid [64];
  logic [28:0] m_line  [64];
  logic [63:0] mem [logic [28:0]];
  int unsigned m_hits = 0;
  int unsigned m_misses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [63:0] mem_line(input logic [28:0] la);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom};
    return mem[la];
  endfunction

  // mode: 0 = normal fill, 1 = clear before mc_done, 2 = clear in the mc_done cycle
  task automatic fetch(input logic [31:0] pc, input int lat, input int mode,
                       input int pre_freeze, input int mid_freeze);
    logic [28:0] la;
    logic [63:0] line;
    logic [31:0] word;
    int          idx;
    bit          is_hit;
    la     = pc[31:3];
    idx    = int'(la % 64);
    line   = mem_line(la);
    word   = pc[2] ? line[63:32] : line[31:0];
    is_hit = m_valid[idx] && (m_line[idx] == la);
    if_req = 1'b1;
    if_pc  = pc;
    if (pre_freeze > 0) begin
      rdy_in = 1'b0;
      repeat (pre_freeze) begin
        cyc();
        check("freeze_req_valid", 64'(if_valid), 64'd0);
      end
      rdy_in = 1'b1;
    end
    cyc();
    if_req = 1'b0;
    if_pc  = $urandom;
    if (is_hit) begin
      m_hits++;
      check("hit_valid", 64'(if_valid), 64'd1);
      check("hit_instr", 64'(if_instr), 64'(word));
      check("hit_mc_signal", 64'(mc_signal), 64'd0);
      cyc();
      check("hit_pulse", 64'(if_valid), 64'd0);
      return;
    end
    m_misses++;
    check("miss_valid", 64'(if_valid), 64'd0);
    check("miss_mc_signal", 64'(mc_signal), 64'd1);
    check("miss_mc_a", 64'(mc_a), 64'({la, 3'b000}));
    repeat (lat) begin
      cyc();
      check("wait_mc_signal", 64'(mc_signal), 64'd1);
    end
    if (mid_freeze > 0) begin
      rdy_in = 1'b0;
      repeat (mid_freeze) begin
        cyc();
        check("freeze_valid", 64'(if_valid), 64'd0);
        check("freeze_mc_signal", 64'(mc_signal), 64'd1);
        check("freeze_mc_a", 64'(mc_a), 64'({la, 3'b000}));
      end
      rdy_in = 1'b1;
    end
    mc_d = line;
    if (mode == 0) begin
      mc_done = 1'b1;
      #1;
      check("done_mc_signal", 64'(mc_signal), 64'd0);
      cyc();
      mc_done = 1'b0;
      mc_d    = {$urandom, $urandom};
      check("fill_valid", 64'(if_valid), 64'd1);
      check("fill_instr", 64'(if_instr), 64'(word));
      check("fill_idle_mc_signal", 64'(mc_signal), 64'd0);
      m_valid[idx] = 1'b1;
      m_line[idx]  = la;
      cyc();
      check("fill_pulse", 64'(if_valid), 64'd0);
    end else begin
      clear_signal = 1'b1;
      mc_done      = (mode == 2);
      #1;
      check("clear_mc_signal", 64'(mc_signal), 64'd0);
      cyc();
      clear_signal = 1'b0;
      mc_done      = 1'b0;
      check("abort_valid", 64'(if_valid), 64'd0);
      check("abort_idle_mc_signal", 64'(mc_signal), 64'd0);
    end
  endtask

  task automatic dropped_req(input logic [31:0] pc);
    if_req       = 1'b1;
    if_pc        = pc;
    clear_signal = 1'b1;
    cyc();
    if_req       = 1'b0;
    clear_signal = 1'b0;
    check("drop_valid", 64'(if_valid), 64'd0);
    check("drop_mc_signal", 64'(mc_signal), 64'd0);
  endtask

  initial begin
    logic [31:0] pc;
    int          r;
    rst_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0; if_req = 1'b0;
    if_pc = '0; mc_d = '0; mc_done = 1'b0;
    mem[29'h0]  = 64'h00A00093_00000513;
    mem[29'h40] = 64'h11111111_22222222;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_instr", 64'(if_instr), 64'd0);
    check("rst_mc_a", 64'(mc_a), 64'd0);
    check("rst_mc_signal", 64'(mc_signal), 64'd0);
    rst_in = 1'b1;
    cyc();

    fetch(32'h0, 2, 0, 0, 0);          // cold miss on line 0
    fetch(32'h4, 0, 0, 0, 0);          // upper word hit
`ifdef ICACHE_PERF_EN
    check("perf_hits_t2", 64'(hit_count), 64'd1);
    check("perf_misses_t2", 64'(miss_count), 64'd1);
`endif
    fetch(32'h200, 1, 0, 0, 0);        // conflicts with line 0
    fetch(32'h0, 0, 0, 0, 0);          // evicted, misses again
    fetch(32'h40, 3, 1, 0, 0);         // aborted fill
    fetch(32'h40, 1, 0, 0, 0);         // line was not written
    fetch(32'h80, 0, 2, 0, 0);         // clear together with mc_done
    fetch(32'h84, 1, 0, 0, 5);         // frozen mid-MISS
    fetch(32'h80, 0, 0, 2, 0);         // hit pending across a freeze
    dropped_req(32'h44);
    fetch(32'h44, 0, 0, 0, 0);         // clear left contents intact
    fetch(32'hFFFF_FFF8, 1, 0, 0, 0);  // top of address space
    fetch(32'h0000_01F8, 0, 0, 0, 0);  // same index, different tag

    for (int i = 0; i < 250; i++) begin
      pc = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 3) |
           ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) pc[31] = 1'b1;
      r = $urandom_range(0, 11);
      if (r == 0) dropped_req(pc);
      else fetch(pc, $urandom_range(0, 4),
                 (r == 1) ? 1 : (r == 2) ? 2 : 0,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0);
    end
`ifdef ICACHE_PERF_EN
    check("perf_hits_end", 64'(hit_count), 64'(m_hits));
    check("perf_misses_end", 64'(miss_count), 64'(m_misses));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
